// File: rtl/master_slave_feeder_pkg.sv
// Shared types and width constants for the master-slave feeder block.
package master_slave_feeder_types;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned EMIT_CNT_W = 16;

  typedef enum logic {
    SECTION_IDLE = 1'b0,
    SECTION_GAP  = 1'b1
  } Sections;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/master_slave_feeder_fifo.sv
// Small circular FIFO; pointers wrap modulo DEPTH (DEPTH is a power of two).
module feeder_fifo
  import master_slave_feeder_types::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [DATA_W-1:0]             data_i,
  output logic [DATA_W-1:0]             head_o,
  output logic [fifo_cnt_w(DEPTH)-1:0]  count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = fifo_cnt_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/master_slave_feeder.sv
// Buffers upstream words, adds OFFSET, and publishes them as held value plus
// 1-cycle sync pulse with at least GAP idle cycles between pulses.
module master_slave_feeder
  import master_slave_feeder_types::*;
#(
  parameter int unsigned       DATA_W = DATA_W_DEF,
  parameter int unsigned       DEPTH  = 4,
  parameter int unsigned       GAP    = 2,
  parameter logic [DATA_W-1:0] OFFSET = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     b_in_sig,
  input  logic                  b_in_sync,
  output logic                  b_in_notify,
  output logic [DATA_W-1:0]     ms_out_sig,
  output logic                  ms_out_sync,
  output logic [EMIT_CNT_W-1:0] emitted_cnt,
  output Sections               dbg_state_o
);

  localparam int unsigned CW = fifo_cnt_w(DEPTH);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  // Handshake: a word moves on a rising edge where b_in_sync && b_in_notify.
  // b_in_notify is a register derived only from the FIFO occupancy, so a pop
  // in the same cycle never lets a full FIFO accept a word.
  Sections               state_q, state_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [DATA_W-1:0]     sig_q, sig_d;
  logic                  sync_q, sync_d;
  logic [EMIT_CNT_W-1:0] emitted_q, emitted_d;
  logic                  notify_q, notify_d;

  logic                  push, pop, full, empty;
  logic [DATA_W-1:0]     head;
  logic [CW-1:0]         count, count_next;

  assign push = b_in_sync && notify_q && !full;

  feeder_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (b_in_sig),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign count_next = count + CW'(push) - CW'(pop);
  assign notify_d   = (count_next != CW'(DEPTH));

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    sig_d     = sig_q;
    sync_d    = 1'b0;
    emitted_d = emitted_q;
    pop       = 1'b0;
    case (state_q)
      SECTION_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          sig_d     = head + OFFSET;
          sync_d    = 1'b1;
          emitted_d = emitted_q + EMIT_CNT_W'(1);
          if (GAP != 0) begin
            state_d = SECTION_GAP;
            gap_d   = GW'(GAP - 1);
          end
        end
      end
      SECTION_GAP: begin
        if (gap_q == '0) state_d = SECTION_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = SECTION_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SECTION_IDLE;
      gap_q     <= '0;
      sig_q     <= '0;
      sync_q    <= 1'b0;
      emitted_q <= '0;
      notify_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      sig_q     <= sig_d;
      sync_q    <= sync_d;
      emitted_q <= emitted_d;
      notify_q  <= notify_d;
    end
  end

  assign b_in_notify = notify_q;
  assign ms_out_sig  = sig_q;
  assign ms_out_sync = sync_q;
  assign emitted_cnt = emitted_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_master_slave_feeder.sv
// Bench for master_slave_feeder: vector table on a GAP=0 instance, directed
// sequences and random traffic on a GAP=2 instance against a queue model.
module tb_master_slave_feeder;
  import master_slave_feeder_types::*;

  localparam int unsigned A_DEPTH = 4;
  localparam int unsigned A_GAP   = 2;
  localparam logic [31:0] A_OFF   = 32'd5;
  localparam logic [31:0] B_OFF   = 32'd1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, sync_a = 1'b0;
  logic [31:0] sig_a = '0;
  logic        notify_a, osync_a;
  logic [31:0] osig_a;
  logic [15:0] cnt_a;
  Sections     st_a;

  logic        rst_b = 1'b0, sync_b = 1'b0;
  logic [31:0] sig_b = '0;
  logic        notify_b, osync_b;
  logic [31:0] osig_b;
  logic [15:0] cnt_b;
  Sections     st_b;

  master_slave_feeder #(.DATA_W(32), .DEPTH(A_DEPTH), .GAP(A_GAP), .OFFSET(A_OFF)) dut_a (
    .clk(clk), .rst(rst_a), .b_in_sig(sig_a), .b_in_sync(sync_a), .b_in_notify(notify_a),
    .ms_out_sig(osig_a), .ms_out_sync(osync_a), .emitted_cnt(cnt_a), .dbg_state_o(st_a)
  );

  master_slave_feeder #(.DATA_W(32), .DEPTH(4), .GAP(0), .OFFSET(B_OFF)) dut_b (
    .clk(clk), .rst(rst_b), .b_in_sig(sig_b), .b_in_sync(sync_b), .b_in_notify(notify_b),
    .ms_out_sig(osig_b), .ms_out_sync(osync_b), .emitted_cnt(cnt_b), .dbg_state_o(st_b)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for dut_a: words waiting in exp_q; a pop is permitted once
  // the cycle number reaches the earliest slot set by the previous pulse.
  logic [31:0] exp_q[$];
  logic [31:0] m_sig;
  logic        m_sync, m_notify;
  logic [15:0] m_cnt;
  int          m_cyc, m_earliest;

  task automatic model_reset();
    exp_q.delete();
    m_sig = '0; m_sync = 1'b0; m_notify = 1'b0; m_cnt = '0;
    m_cyc = 0; m_earliest = 0;
  endtask

  task automatic model_edge(input logic rst_lvl, input logic s, input logic [31:0] d);
    logic take;
    if (!rst_lvl) begin
      model_reset();
    end else begin
      take = s && m_notify;
      if (exp_q.size() > 0 && m_cyc >= m_earliest) begin
        m_sig      = exp_q.pop_front() + A_OFF;
        m_sync     = 1'b1;
        m_cnt      = m_cnt + 16'd1;
        m_earliest = m_cyc + int'(A_GAP) + 1;
      end else begin
        m_sync = 1'b0;
      end
      if (take) exp_q.push_back(d);
      m_notify = (exp_q.size() < A_DEPTH);
      m_cyc++;
    end
  endtask

  // pulses observed on dut_a, with local cycle index
  logic [31:0] pv[$];
  int          pc[$];
  int          tcyc = 0;

  // ---------------- driver tasks ----------------
  task automatic step_a(input logic s, input logic [31:0] d);
    sync_a = s;
    sig_a  = d;
    @(posedge clk);
    model_edge(rst_a, s, d);
    #1;
    chk("a_sig",    osig_a,   m_sig);
    chk("a_sync",   osync_a,  32'(m_sync));
    chk("a_cnt",    cnt_a,    32'(m_cnt));
    chk("a_notify", notify_a, 32'(m_notify));
    if (osync_a) begin
      pv.push_back(osig_a);
      pc.push_back(tcyc);
    end
    tcyc++;
  endtask

  typedef struct {
    logic        rst_n;
    logic        sync;
    logic [31:0] sig;
    logic        e_notify;
    logic        e_sync;
    logic [31:0] e_sig;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic s, input logic [31:0] d,
                               input logic en, input logic es, input logic [31:0] ed,
                               input logic [15:0] ec);
    vec_t v;
    v.rst_n = r; v.sync = s; v.sig = d;
    v.e_notify = en; v.e_sync = es; v.e_sig = ed; v.e_cnt = ec;
    return v;
  endfunction

  vec_t vt[$];
  logic saw_full;

  initial begin
    // ---- vector table for dut_b (GAP=0, OFFSET=1) ----
    vt.push_back(mkv(0, 0, 32'd0,          0, 0, 32'd0,  16'd0));
    vt.push_back(mkv(1, 0, 32'd0,          1, 0, 32'd0,  16'd0));
    vt.push_back(mkv(1, 1, 32'hFFFF_FFFF,  1, 0, 32'd0,  16'd0));
    vt.push_back(mkv(1, 1, 32'd10,         1, 1, 32'd0,  16'd1));
    vt.push_back(mkv(1, 1, 32'd20,         1, 1, 32'd11, 16'd2));
    vt.push_back(mkv(1, 0, 32'd0,          1, 1, 32'd21, 16'd3));
    vt.push_back(mkv(1, 0, 32'd0,          1, 0, 32'd21, 16'd3));
    vt.push_back(mkv(1, 1, 32'd100,        1, 0, 32'd21, 16'd3));
    for (int i = 1; i <= 7; i++)
      vt.push_back(mkv(1, 1, 32'(100 + i), 1, 1, 32'(100 + i), 16'(3 + i)));
    vt.push_back(mkv(1, 0, 32'd0,          1, 1, 32'd108, 16'd11));
    vt.push_back(mkv(1, 0, 32'd0,          1, 0, 32'd108, 16'd11));

    @(posedge clk); #1;
    chk("b_reset_sig",    osig_b,   32'd0);
    chk("b_reset_notify", notify_b, 32'd0);
    for (int i = 0; i < vt.size(); i++) begin
      rst_b  = vt[i].rst_n;
      sync_b = vt[i].sync;
      sig_b  = vt[i].sig;
      @(posedge clk); #1;
      chk($sformatf("b_vec%0d_notify", i), notify_b, 32'(vt[i].e_notify));
      chk($sformatf("b_vec%0d_sync", i),   osync_b,  32'(vt[i].e_sync));
      chk($sformatf("b_vec%0d_sig", i),    osig_b,   vt[i].e_sig);
      chk($sformatf("b_vec%0d_cnt", i),    cnt_b,    32'(vt[i].e_cnt));
    end

    // ---- emitted_cnt wrap on dut_b ----
    force dut_b.emitted_q = 16'hFFFE;
    #1;
    release dut_b.emitted_q;
    chk("b_wrap_preload", cnt_b, 32'hFFFE);
    sync_b = 1'b1; sig_b = 32'd5;
    @(posedge clk); #1;
    chk("b_wrap_sync0", osync_b, 32'd0);
    sync_b = 1'b1; sig_b = 32'd6;
    @(posedge clk); #1;
    chk("b_wrap_cnt_ffff", cnt_b,  32'hFFFF);
    chk("b_wrap_sig1",     osig_b, 32'd6);
    sync_b = 1'b0; sig_b = 32'd0;
    @(posedge clk); #1;
    chk("b_wrap_cnt_0000", cnt_b,   32'h0000);
    chk("b_wrap_sig2",     osig_b,  32'd7);
    chk("b_wrap_sync2",    osync_b, 32'd1);

    // ---- dut_a: reset and release ----
    model_reset();
    chk("a_reset_sig",    osig_a,   32'd0);
    chk("a_reset_sync",   osync_a,  32'd0);
    chk("a_reset_notify", notify_a, 32'd0);
    step_a(0, 0);
    rst_a = 1'b1;
    step_a(0, 0);
    chk("a_notify_rise", notify_a, 32'd1);
    step_a(0, 0);

    // single word: latency and hold
    step_a(1, 32'd10);
    chk("t1_no_pulse_yet", osync_a, 32'd0);
    step_a(0, 0);
    chk("t1_pulse", osync_a, 32'd1);
    chk("t1_sig",   osig_a,  32'd15);
    chk("t1_cnt",   cnt_a,   32'd1);
    step_a(0, 0);
    chk("t1_pulse_once", osync_a, 32'd0);
    chk("t1_sig_held",   osig_a,  32'd15);
    for (int i = 0; i < 4; i++) step_a(0, 0);

    // burst 1..4: order and spacing
    pv.delete(); pc.delete();
    for (int i = 1; i <= 4; i++) step_a(1, 32'(i));
    for (int i = 0; i < 14; i++) step_a(0, 0);
    chk("t2_npulse", pv.size(), 32'd4);
    for (int i = 0; i < pv.size(); i++) chk($sformatf("t2_val%0d", i), pv[i], 32'(i + 6));
    for (int i = 1; i < pc.size(); i++)
      chk($sformatf("t2_space%0d", i), 32'(pc[i] - pc[i-1]), 32'(A_GAP + 1));

    // fill with a continuous source; refusal and recovery
    saw_full = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step_a(1, 32'(200 + i));
      if (!notify_a) saw_full = 1'b1;
    end
    chk("t3_full_seen", 32'(saw_full), 32'd1);
    for (int i = 0; i < 10 && !notify_a; i++) step_a(0, 0);
    chk("t3_notify_back", notify_a, 32'd1);
    for (int i = 0; i < 20; i++) step_a(0, 0);
    chk("t3_drained_cnt", cnt_a, 32'(m_cnt));

    // reset with three words buffered
    for (int i = 0; i < 10 && exp_q.size() != 3; i++) step_a(1, 32'(300 + i));
    chk("t6_setup", 32'(exp_q.size()), 32'd3);
    sync_a = 1'b0;
    #2;
    rst_a = 1'b0;
    #1;
    model_reset();
    chk("t6_async_sig",    osig_a,   32'd0);
    chk("t6_async_sync",   osync_a,  32'd0);
    chk("t6_async_cnt",    cnt_a,    32'd0);
    chk("t6_async_notify", notify_a, 32'd0);
    step_a(0, 0);
    step_a(0, 0);
    rst_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_a(0, 0);
      chk("t6_no_pulse", osync_a, 32'd0);
    end
    step_a(1, 32'd77);
    step_a(0, 0);
    chk("t6_new_sync", osync_a, 32'd1);
    chk("t6_new_sig",  osig_a,  32'd82);
    chk("t6_new_cnt",  cnt_a,   32'd1);

    // random traffic with varying source rate
    for (int i = 0; i < 400; i++) begin
      int rate;
      rate = (i < 150) ? 90 : (i < 300) ? 30 : 60;
      step_a(($urandom_range(0, 99) < rate) ? 1'b1 : 1'b0, $urandom);
    end
    for (int i = 0; i < 20; i++) step_a(0, 0);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
